// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core fetch/data ports, the arbiter and the unified memory.
// slave: arbiter view; master: core + memory environment view.
interface riscv_mem_arbiter_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] imem_addr;
   logic            imem_req;
   logic [31:0]     imem_rdata;
   logic            imem_ready;

   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_we;
   logic            dmem_req;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ready;

   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_we;
   logic            mem_req;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   logic            arb_err;

   modport slave (
      input  imem_addr, imem_req, dmem_addr, dmem_wdata, dmem_we, dmem_req,
             mem_gnt, mem_rvalid, mem_rdata,
      output imem_rdata, imem_ready, dmem_rdata, dmem_ready,
             mem_addr, mem_wdata, mem_we, mem_req, arb_err
   );

   modport master (
      output imem_addr, imem_req, dmem_addr, dmem_wdata, dmem_we, dmem_req,
             mem_gnt, mem_rvalid, mem_rdata,
      input  imem_rdata, imem_ready, dmem_rdata, dmem_ready,
             mem_addr, mem_wdata, mem_we, mem_req, arb_err
   );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory; data has priority with a streak limit.
// Optional watchdog enabled by defining RISCV_ARB_TIMEOUT_EN.
module riscv_mem_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned DSTREAK_MAX    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                clk,
   input logic                rst,
   riscv_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

   localparam logic [3:0] StreakMax = 4'(DSTREAK_MAX);

   state_e          state_q;
   logic [3:0]      streak_q;
   logic            src_data_q;
   logic            grant_data;
   logic            tmo_fire;
   logic            finish;
   logic [XLEN-1:0] resp_data;

   // Data wins unless a fetch has waited through a full data streak.
   assign grant_data = bus.dmem_req && !(bus.imem_req && streak_q == StreakMax);
   assign finish     = (state_q == StResp && bus.mem_rvalid) || tmo_fire;
   assign resp_data  = tmo_fire ? XLEN'(32'hDEAD_BEEF) : bus.mem_rdata;

`ifdef RISCV_ARB_TIMEOUT_EN
   localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   logic [TmoW-1:0] tmo_q;

   assign tmo_fire = (tmo_q == TmoLast) &&
                     ((state_q == StReq && !bus.mem_gnt) || (state_q == StResp && !bus.mem_rvalid));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q       <= '0;
         bus.arb_err <= 1'b0;
      end else begin
         if (state_q == StReq || state_q == StResp) begin
            tmo_q <= tmo_q + TmoW'(1);
         end else begin
            tmo_q <= '0;
         end
         if (tmo_fire) begin
            bus.arb_err <= 1'b1;
         end
      end
   end
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_fire       = 1'b0;
   assign bus.arb_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         streak_q       <= '0;
         src_data_q     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_we     <= '0;
         bus.mem_req    <= 1'b0;
         bus.imem_rdata <= '0;
         bus.imem_ready <= 1'b0;
         bus.dmem_rdata <= '0;
         bus.dmem_ready <= 1'b0;
      end else begin
         bus.imem_ready <= 1'b0;
         bus.dmem_ready <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_data) begin
                  bus.mem_addr  <= bus.dmem_addr;
                  bus.mem_wdata <= bus.dmem_wdata;
                  bus.mem_we    <= bus.dmem_we;
                  bus.mem_req   <= 1'b1;
                  src_data_q    <= 1'b1;
                  state_q       <= StReq;
                  if (!bus.imem_req) begin
                     streak_q <= '0;
                  end else if (streak_q != StreakMax) begin
                     streak_q <= streak_q + 4'd1;
                  end
               end else if (bus.imem_req) begin
                  bus.mem_addr  <= bus.imem_addr;
                  bus.mem_wdata <= '0;
                  bus.mem_we    <= '0;
                  bus.mem_req   <= 1'b1;
                  src_data_q    <= 1'b0;
                  state_q       <= StReq;
                  streak_q      <= '0;
               end
            end
            StReq, StResp: begin
               if (state_q == StReq && bus.mem_gnt) begin
                  bus.mem_req <= 1'b0;
                  state_q     <= StResp;
               end else if (finish) begin
                  bus.mem_req <= 1'b0;
                  state_q     <= StDone;
                  if (src_data_q) begin
                     bus.dmem_rdata <= resp_data;
                     bus.dmem_ready <= 1'b1;
                  end else begin
                     bus.imem_rdata <= resp_data[31:0];
                     bus.imem_ready <= 1'b1;
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: fetch, collision, streak limit, stalls, reset, timeout.
module tb_riscv_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   riscv_mem_arbiter_if #(.XLEN(32)) bus ();

   riscv_mem_arbiter #(
      .XLEN          (32),
      .DSTREAK_MAX   (4),
      .TIMEOUT_CYCLES(16)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'h13 : {a[15:0], ~a[15:0]};
   endfunction

   // Memory responder: gnt after gnt_dly REQ cycles, rvalid rv_dly cycles after gnt.
   int          gnt_dly    = 0;
   int          rv_dly     = 1;
   bit          gnt_never  = 1'b0;
   int          age        = 0;
   int          rv_cnt     = 0;
   logic [31:0] pending    = '0;

   initial begin
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hBAD0_0000;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_gnt    = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = 32'hBAD0_0000;
         if (rst) begin
            rv_cnt = 0;
            age    = 0;
         end else if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = pending;
            end
         end else if (bus.mem_req && !gnt_never) begin
            if (age == gnt_dly) begin
               bus.mem_gnt = 1'b1;
               pending     = mem_model(bus.mem_addr);
               rv_cnt      = rv_dly;
               age         = 0;
            end else begin
               age++;
            end
         end else if (!bus.mem_req) begin
            age = 0;
         end
      end
   end

   logic [31:0] grants[$];
   int          n_ipulse = 0;
   int          n_dpulse = 0;
   int          n_both   = 0;

   always @(negedge clk) begin
      if (bus.mem_req && bus.mem_gnt) grants.push_back(bus.mem_addr);
      if (bus.imem_ready) n_ipulse++;
      if (bus.dmem_ready) n_dpulse++;
      if (bus.imem_ready && bus.dmem_ready) n_both++;
   end

   // Counts negedges from the call until the selected ready is seen.
   task automatic wait_ready(input string tag, input bit data, input int budget, output int lat);
      bit found;
      found = 1'b0;
      lat   = 0;
      while (!found && lat < budget) begin
         @(negedge clk);
         lat++;
         found = data ? bus.dmem_ready : bus.imem_ready;
      end
      check({tag, "_ready_seen"}, 64'(found), 64'd1);
   endtask

   initial begin
      int lat;
      int snap;

      bus.imem_addr  = '0;
      bus.imem_req   = 1'b0;
      bus.dmem_addr  = '0;
      bus.dmem_wdata = '0;
      bus.dmem_we    = '0;
      bus.dmem_req   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_imem_ready", 64'(bus.imem_ready), 64'd0);
      check("rst_dmem_ready", 64'(bus.dmem_ready), 64'd0);
      check("rst_imem_rdata", 64'(bus.imem_rdata), 64'd0);
      check("rst_arb_err", 64'(bus.arb_err), 64'd0);

      // T1: single fetch, ready in the 4th cycle counting the request cycle.
      @(negedge clk);
      bus.imem_addr = 32'h100;
      bus.imem_req  = 1'b1;
      wait_ready("t1", 1'b0, 10, lat);
      bus.imem_req = 1'b0;
      check("t1_latency", 64'(lat), 64'd3);
      check("t1_rdata", 64'(bus.imem_rdata), 64'h13);
      check("t1_mem_we", 64'(bus.mem_we), 64'd0);
      check("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
      @(negedge clk);
      check("t1_pulse_width", 64'(bus.imem_ready), 64'd0);

      // T2: collision, data first.
      grants.delete();
      bus.imem_addr  = 32'h200;
      bus.imem_req   = 1'b1;
      bus.dmem_addr  = 32'h2000;
      bus.dmem_wdata = 32'hA5A5_A5A5;
      bus.dmem_we    = 4'hF;
      bus.dmem_req   = 1'b1;
      @(negedge clk);
      check("t2_mem_we", 64'(bus.mem_we), 64'hF);
      check("t2_mem_addr", 64'(bus.mem_addr), 64'h2000);
      check("t2_mem_wdata", 64'(bus.mem_wdata), 64'hA5A5_A5A5);
      wait_ready("t2d", 1'b1, 10, lat);
      bus.dmem_req = 1'b0;
      check("t2_dmem_rdata", 64'(bus.dmem_rdata), 64'(mem_model(32'h2000)));
      check("t2_no_fetch_yet", 64'(bus.imem_ready), 64'd0);
      wait_ready("t2i", 1'b0, 10, lat);
      bus.imem_req = 1'b0;
      check("t2_imem_rdata", 64'(bus.imem_rdata), 64'(mem_model(32'h200)));
      check("t2_fetch_we", 64'(bus.mem_we), 64'd0);
      check("t2_ngrants", 64'(grants.size()), 64'd2);
      if (grants.size() == 2) begin
         check("t2_order0", 64'(grants[0]), 64'h2000);
         check("t2_order1", 64'(grants[1]), 64'h200);
      end

      // T3: streak limit, four data grants then one fetch.
      @(negedge clk);
      grants.delete();
      bus.imem_addr = 32'h300;
      bus.imem_req  = 1'b1;
      bus.dmem_addr = 32'h3000;
      bus.dmem_we   = 4'h0;
      bus.dmem_req  = 1'b1;
      lat = 0;
      while (grants.size() < 10 && lat < 80) begin
         @(negedge clk);
         lat++;
      end
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      check("t3_grants_seen", 64'(grants.size() >= 10), 64'd1);
      repeat (8) @(negedge clk);
      if (grants.size() >= 10) begin
         for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_grant%0d", i), 64'(grants[i]),
                  (i % 5 == 4) ? 64'h300 : 64'h3000);
         end
      end

      // T4: stalled memory; fields held through REQ, requester changes ignored.
      gnt_dly        = 3;
      rv_dly         = 5;
      snap           = n_dpulse;
      bus.dmem_addr  = 32'h4000;
      bus.dmem_wdata = 32'h1234_5678;
      bus.dmem_we    = 4'h3;
      bus.dmem_req   = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("t4_req%0d", i), 64'(bus.mem_req), 64'd1);
         check($sformatf("t4_addr%0d", i), 64'(bus.mem_addr), 64'h4000);
         check($sformatf("t4_wdata%0d", i), 64'(bus.mem_wdata), 64'h1234_5678);
         bus.dmem_addr  = 32'hFFFF_0000;
         bus.dmem_wdata = 32'h0;
      end
      check("t4_we", 64'(bus.mem_we), 64'h3);
      wait_ready("t4", 1'b1, 20, lat);
      bus.dmem_req = 1'b0;
      check("t4_rdata", 64'(bus.dmem_rdata), 64'(mem_model(32'h4000)));
      repeat (4) @(negedge clk);
      check("t4_one_pulse", 64'(n_dpulse - snap), 64'd1);
      check("t4_req_low", 64'(bus.mem_req), 64'd0);

      // T5: reset during RESP aborts without a pulse.
      gnt_dly       = 0;
      rv_dly        = 4;
      snap          = n_ipulse;
      bus.imem_addr = 32'h500;
      bus.imem_req  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst          = 1'b1;
      bus.imem_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("t5_mem_req", 64'(bus.mem_req), 64'd0);
      check("t5_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("t5_imem_rdata", 64'(bus.imem_rdata), 64'd0);
      check("t5_dmem_rdata", 64'(bus.dmem_rdata), 64'd0);
      repeat (6) @(negedge clk);
      check("t5_no_pulse", 64'(n_ipulse - snap), 64'd0);
      rv_dly        = 1;
      bus.imem_addr = 32'h600;
      bus.imem_req  = 1'b1;
      wait_ready("t5", 1'b0, 10, lat);
      bus.imem_req = 1'b0;
      check("t5_latency", 64'(lat), 64'd3);
      check("t5_rdata", 64'(bus.imem_rdata), 64'(mem_model(32'h600)));

`ifdef RISCV_ARB_TIMEOUT_EN
      // T6: gnt never comes; watchdog completes with a poison word.
      @(negedge clk);
      gnt_never     = 1'b1;
      bus.dmem_addr = 32'h7000;
      bus.dmem_we   = 4'h0;
      bus.dmem_req  = 1'b1;
      wait_ready("t6", 1'b1, 40, lat);
      bus.dmem_req = 1'b0;
      gnt_never    = 1'b0;
      check("t6_latency", 64'(lat), 64'd17);
      check("t6_rdata", 64'(bus.dmem_rdata), 64'hDEAD_BEEF);
      check("t6_err_set", 64'(bus.arb_err), 64'd1);
      bus.imem_addr = 32'h100;
      bus.imem_req  = 1'b1;
      wait_ready("t6f", 1'b0, 10, lat);
      bus.imem_req = 1'b0;
      check("t6_fetch_rdata", 64'(bus.imem_rdata), 64'h13);
      check("t6_err_sticky", 64'(bus.arb_err), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_err_cleared", 64'(bus.arb_err), 64'd0);
`else
      check("arb_err_tied", 64'(bus.arb_err), 64'd0);
`endif

      check("ready_exclusive", 64'(n_both), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "bench watchdog expired");
   end

endmodule
